// File: rtl/rc4_prga_decrypt_if.sv
// Bus bundle between the RC4 PRGA decrypt core and its S-array RAM, ciphertext ROM and plaintext RAM.
// The core drives addresses, write data and enables; the memories and host side drive start and read data.
interface rc4_prga_decrypt_if #(
  parameter int MSG_LEN = 32
);
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic          start;
  logic [7:0]    s_addr;
  logic [7:0]    s_data;
  logic          s_wren;
  logic [7:0]    s_q;
  logic [AW-1:0] enc_addr;
  logic [7:0]    enc_q;
  logic [AW-1:0] dec_addr;
  logic [7:0]    dec_data;
  logic          dec_wren;
  logic          done;
  logic          msg_valid;

  modport master (
    input  start, s_q, enc_q,
    output s_addr, s_data, s_wren, enc_addr, dec_addr, dec_data, dec_wren, done, msg_valid
  );

  modport slave (
    output start, s_q, enc_q,
    input  s_addr, s_data, s_wren, enc_addr, dec_addr, dec_data, dec_wren, done, msg_valid
  );
endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA over a preloaded S-array: decrypts MSG_LEN ciphertext bytes, aborting on the first non-text byte.
// Every memory read waits RD_WAIT cycles before capture; the memories cannot stall the core.
module rc4_prga_decrypt #(
  parameter int MSG_LEN = 32,
  parameter int RD_WAIT = 2
) (
  input  logic               clk,
  input  logic               master_reset_n,
  rc4_prga_decrypt_if.master bus
);
  localparam int         AW       = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam logic [7:0] K_LAST   = 8'(MSG_LEN - 1);
  localparam logic [7:0] W_LAST   = 8'(RD_WAIT - 1);
  localparam bit         HAS_WAIT = (RD_WAIT > 0);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WAIT_A, CAP_SI, RD_SJ, WAIT_B, CAP_SJ, WR_I,
    WR_J, RD_F, WAIT_C, CAP_F, WR_DEC, NEXT, DONE
  } state_t;

  function automatic logic is_text(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  state_t        state_q, state_d;
  logic [7:0]    i_q, i_d, j_q, j_d, k_q, k_d;
  logic [7:0]    si_q, si_d, sj_q, sj_d, pt_q, pt_d, wait_q, wait_d;
  logic          valid_q, valid_d;
  logic [7:0]    s_addr_q, s_addr_d, s_data_q, s_data_d;
  logic          s_wren_q, s_wren_d;
  logic [AW-1:0] enc_addr_q, enc_addr_d, dec_addr_q, dec_addr_d;
  logic [7:0]    dec_data_q, dec_data_d;
  logic          dec_wren_q, dec_wren_d, done_q, done_d, msg_valid_q, msg_valid_d;

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    si_d        = si_q;
    sj_d        = sj_q;
    pt_d        = pt_q;
    wait_d      = wait_q;
    valid_d     = valid_q;
    s_addr_d    = s_addr_q;
    s_data_d    = s_data_q;
    s_wren_d    = 1'b0;
    enc_addr_d  = enc_addr_q;
    dec_addr_d  = dec_addr_q;
    dec_data_d  = dec_data_q;
    dec_wren_d  = 1'b0;
    done_d      = done_q;
    msg_valid_d = msg_valid_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        i_d         = 8'd0;
        j_d         = 8'd0;
        k_d         = 8'd0;
        done_d      = 1'b0;
        msg_valid_d = 1'b0;
        valid_d     = 1'b1;
        state_d     = RD_SI;
      end
      RD_SI: begin
        i_d      = i_q + 8'd1;
        s_addr_d = i_q + 8'd1;
        wait_d   = 8'd0;
        state_d  = HAS_WAIT ? WAIT_A : CAP_SI;
      end
      WAIT_A: begin
        wait_d = wait_q + 8'd1;
        if (wait_q == W_LAST) state_d = CAP_SI;
      end
      CAP_SI: begin
        si_d    = bus.s_q;
        j_d     = j_q + bus.s_q;
        state_d = RD_SJ;
      end
      RD_SJ: begin
        s_addr_d = j_q;
        wait_d   = 8'd0;
        state_d  = HAS_WAIT ? WAIT_B : CAP_SJ;
      end
      WAIT_B: begin
        wait_d = wait_q + 8'd1;
        if (wait_q == W_LAST) state_d = CAP_SJ;
      end
      CAP_SJ: begin
        sj_d    = bus.s_q;
        state_d = WR_I;
      end
      // s[j] is written last so that i==j leaves saved_si in place.
      WR_I: begin
        s_addr_d = i_q;
        s_data_d = sj_q;
        s_wren_d = 1'b1;
        state_d  = WR_J;
      end
      WR_J: begin
        s_addr_d = j_q;
        s_data_d = si_q;
        s_wren_d = 1'b1;
        state_d  = RD_F;
      end
      RD_F: begin
        s_addr_d   = si_q + sj_q;
        enc_addr_d = k_q[AW-1:0];
        wait_d     = 8'd0;
        state_d    = HAS_WAIT ? WAIT_C : CAP_F;
      end
      WAIT_C: begin
        wait_d = wait_q + 8'd1;
        if (wait_q == W_LAST) state_d = CAP_F;
      end
      CAP_F: begin
        pt_d    = bus.s_q ^ bus.enc_q;
        state_d = WR_DEC;
      end
      WR_DEC: begin
        dec_addr_d = k_q[AW-1:0];
        dec_data_d = pt_q;
        dec_wren_d = 1'b1;
        if (!is_text(pt_q)) valid_d = 1'b0;
        state_d = NEXT;
      end
      NEXT: begin
        if ((k_q == K_LAST) || !valid_q) begin
          done_d      = 1'b1;
          msg_valid_d = valid_q;
          state_d     = DONE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = RD_SI;
        end
      end
      DONE: if (!bus.start) begin
        done_d      = 1'b0;
        msg_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      state_q     <= IDLE;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      k_q         <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      pt_q        <= 8'd0;
      wait_q      <= 8'd0;
      valid_q     <= 1'b0;
      s_addr_q    <= 8'd0;
      s_data_q    <= 8'd0;
      s_wren_q    <= 1'b0;
      enc_addr_q  <= '0;
      dec_addr_q  <= '0;
      dec_data_q  <= 8'd0;
      dec_wren_q  <= 1'b0;
      done_q      <= 1'b0;
      msg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      pt_q        <= pt_d;
      wait_q      <= wait_d;
      valid_q     <= valid_d;
      s_addr_q    <= s_addr_d;
      s_data_q    <= s_data_d;
      s_wren_q    <= s_wren_d;
      enc_addr_q  <= enc_addr_d;
      dec_addr_q  <= dec_addr_d;
      dec_data_q  <= dec_data_d;
      dec_wren_q  <= dec_wren_d;
      done_q      <= done_d;
      msg_valid_q <= msg_valid_d;
    end
  end

  assign bus.s_addr    = s_addr_q;
  assign bus.s_data    = s_data_q;
  assign bus.s_wren    = s_wren_q;
  assign bus.enc_addr  = enc_addr_q;
  assign bus.dec_addr  = dec_addr_q;
  assign bus.dec_data  = dec_data_q;
  assign bus.dec_wren  = dec_wren_q;
  assign bus.done      = done_q;
  assign bus.msg_valid = msg_valid_q;
endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: a 3-byte instance for directed vectors and a 32-byte instance
// checked against a software RC4 PRGA model, each with its own memory models.
module tb_rc4_prga_decrypt;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, load_a, load_b;
  int   n_vec, n_err;

  rc4_prga_decrypt_if #(.MSG_LEN(3))  ifa ();
  rc4_prga_decrypt_if #(.MSG_LEN(32)) ifb ();

  rc4_prga_decrypt #(.MSG_LEN(3),  .RD_WAIT(2)) dut_a (.clk(clk), .master_reset_n(rst_a_n), .bus(ifa.master));
  rc4_prga_decrypt #(.MSG_LEN(32), .RD_WAIT(2)) dut_b (.clk(clk), .master_reset_n(rst_b_n), .bus(ifb.master));

  // Synchronous memories with one cycle read latency; load_x reinitialises them.
  logic [7:0] sa[256], sa_init[256], ea[4], da[4];
  logic [7:0] sb[256], sb_init[256], eb[32], db[32];
  int         sa_wr, da_wr, sb_wr, db_wr;

  always @(posedge clk) begin
    if (load_a) begin
      sa    <= sa_init;
      da    <= '{default: 8'hEE};
      sa_wr <= 0;
      da_wr <= 0;
    end else begin
      if (ifa.s_wren) begin sa[ifa.s_addr] <= ifa.s_data; sa_wr <= sa_wr + 1; end
      if (ifa.dec_wren) begin da[ifa.dec_addr] <= ifa.dec_data; da_wr <= da_wr + 1; end
    end
    ifa.s_q   <= sa[ifa.s_addr];
    ifa.enc_q <= ea[ifa.enc_addr];
  end

  always @(posedge clk) begin
    if (load_b) begin
      sb    <= sb_init;
      db    <= '{default: 8'hEE};
      sb_wr <= 0;
      db_wr <= 0;
    end else begin
      if (ifb.s_wren) begin sb[ifb.s_addr] <= ifb.s_data; sb_wr <= sb_wr + 1; end
      if (ifb.dec_wren) begin db[ifb.dec_addr] <= ifb.dec_data; db_wr <= db_wr + 1; end
    end
    ifb.s_q   <= sb[ifb.s_addr];
    ifb.enc_q <= eb[ifb.enc_addr];
  end

  typedef struct {
    string           name;
    logic [2:0][7:0] enc;
    logic [2:0][7:0] dec;
    logic            valid;
    int              nwr;
  } vec_t;

  vec_t       vt[7];
  logic [7:0] addr_q[$];
  logic [7:0] ms[256], ks[32], md[32];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit is_text(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  task automatic load_a_mem();
    load_a = 1'b1;
    @(negedge clk);
    load_a = 1'b0;
  endtask

  task automatic load_b_mem();
    load_b = 1'b1;
    @(negedge clk);
    load_b = 1'b0;
  endtask

  task automatic run_a(input string tag);
    int n = 0;
    logic [7:0] prev = ifa.s_addr;
    addr_q.delete();
    ifa.start = 1'b1;
    while (ifa.done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (ifa.s_addr !== prev) begin addr_q.push_back(ifa.s_addr); prev = ifa.s_addr; end
    end
    check({tag, "_done"}, 32'(ifa.done), 32'd1);
  endtask

  task automatic run_b(input string tag);
    int n = 0;
    ifb.start = 1'b1;
    while (ifb.done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    check({tag, "_done"}, 32'(ifb.done), 32'd1);
  endtask

  task automatic end_a(input string tag);
    ifa.start = 1'b0;
    @(negedge clk);
    check({tag, "_done_drop"}, 32'({ifa.done, ifa.msg_valid}), 32'd0);
  endtask

  task automatic end_b(input string tag);
    ifb.start = 1'b0;
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(ifb.done), 32'd0);
  endtask

  task automatic ks_gen(input int n);
    logic [7:0] i, j, t, idx;
    for (int x = 0; x < 256; x++) ms[x] = sb_init[x];
    i = 8'd0;
    j = 8'd0;
    for (int k = 0; k < n; k++) begin
      i     = i + 8'd1;
      j     = j + ms[i];
      t     = ms[i];
      ms[i] = ms[j];
      ms[j] = t;
      idx   = ms[i] + ms[j];
      ks[k] = ms[idx];
    end
  endtask

  task automatic rand_perm_b();
    logic [7:0] t;
    int y;
    for (int x = 0; x < 256; x++) sb_init[x] = 8'(x);
    for (int x = 255; x > 0; x--) begin
      y          = $urandom_range(x, 0);
      t          = sb_init[x];
      sb_init[x] = sb_init[y];
      sb_init[y] = t;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad, n, mnwr, mism;
    logic mvalid;
    logic [7:0] pt;

    vt[0] = '{name: "abc",      enc: {8'h64, 8'h67, 8'h63}, dec: {8'h63, 8'h62, 8'h61}, valid: 1'b1, nwr: 3};
    vt[1] = '{name: "nul_k0",   enc: {8'h64, 8'h67, 8'h02}, dec: {8'hEE, 8'hEE, 8'h00}, valid: 1'b0, nwr: 1};
    vt[2] = '{name: "spaces",   enc: {8'h27, 8'h25, 8'h22}, dec: {8'h20, 8'h20, 8'h20}, valid: 1'b1, nwr: 3};
    vt[3] = '{name: "zzz",      enc: {8'h7D, 8'h7F, 8'h78}, dec: {8'h7A, 8'h7A, 8'h7A}, valid: 1'b1, nwr: 3};
    vt[4] = '{name: "x60_k1",   enc: {8'h64, 8'h65, 8'h63}, dec: {8'hEE, 8'h60, 8'h61}, valid: 1'b0, nwr: 2};
    vt[5] = '{name: "x7b_k0",   enc: {8'h64, 8'h67, 8'h79}, dec: {8'hEE, 8'hEE, 8'h7B}, valid: 1'b0, nwr: 1};
    vt[6] = '{name: "x21_last", enc: {8'h26, 8'h67, 8'h63}, dec: {8'h21, 8'h62, 8'h61}, valid: 1'b0, nwr: 3};

    n_vec = 0;
    n_err = 0;
    load_a = 1'b0;
    load_b = 1'b0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    for (int x = 0; x < 256; x++) begin sa_init[x] = 8'(x); sb_init[x] = 8'(x); end
    for (int x = 0; x < 4; x++) ea[x] = 8'h00;
    for (int x = 0; x < 32; x++) eb[x] = 8'h00;
    repeat (3) @(negedge clk);

    check("rst_a_s",    32'({ifa.s_addr, ifa.s_data, ifa.s_wren}), 32'd0);
    check("rst_a_dec",  32'({ifa.enc_addr, ifa.dec_addr, ifa.dec_data, ifa.dec_wren}), 32'd0);
    check("rst_a_flag", 32'({ifa.done, ifa.msg_valid}), 32'd0);
    check("rst_b_s",    32'({ifb.s_addr, ifb.s_data, ifb.s_wren}), 32'd0);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(negedge clk);

    // Identity S gives keystream 0x02, 0x05, 0x07 for the first three bytes.
    for (int v = 0; v < 7; v++) begin
      for (int x = 0; x < 256; x++) sa_init[x] = 8'(x);
      for (int x = 0; x < 3; x++) ea[x] = vt[v].enc[x];
      load_a_mem();
      run_a(vt[v].name);
      check({vt[v].name, "_valid"}, 32'(ifa.msg_valid), 32'(vt[v].valid));
      check({vt[v].name, "_nwr"}, 32'(da_wr), 32'(vt[v].nwr));
      for (int x = 0; x < 3; x++)
        check($sformatf("%s_dec%0d", vt[v].name, x), 32'(da[x]), 32'(vt[v].dec[x]));
      if (v == 0) begin
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (ifa.done !== 1'b1 || ifa.s_wren !== 1'b0 || ifa.dec_wren !== 1'b0) bad++;
        end
        check("hold_done_stable", 32'(bad), 32'd0);
        check("hold_no_rerun", 32'(da_wr), 32'd3);
      end
      end_a(vt[v].name);
    end

    // s[1]=0xFF: j wraps to 0xFF and the keystream address 0xFF+0x01 wraps to 0x00.
    for (int x = 0; x < 256; x++) sa_init[x] = 8'(x);
    sa_init[1]   = 8'hFF;
    sa_init[255] = 8'h01;
    ea[0] = 8'h61;
    ea[1] = 8'h00;
    ea[2] = 8'h00;
    load_a_mem();
    run_a("wrap");
    check("wrap_nlog", 32'(addr_q.size() >= 5), 32'd1);
    if (addr_q.size() >= 5) begin
      check("wrap_a0", 32'(addr_q[0]), 32'h01);
      check("wrap_a1", 32'(addr_q[1]), 32'hFF);
      check("wrap_a2", 32'(addr_q[2]), 32'h01);
      check("wrap_a3", 32'(addr_q[3]), 32'hFF);
      check("wrap_a4", 32'(addr_q[4]), 32'h00);
    end
    check("wrap_dec0", 32'(da[0]), 32'h61);
    end_a("wrap");

    // Reset pulse while byte 5 sits in WR_J (its WR_I write is visible, not yet committed).
    rand_perm_b();
    ks_gen(32);
    for (int k = 0; k < 32; k++) eb[k] = ks[k] ^ (8'h61 + 8'($urandom_range(25, 0)));
    load_b_mem();
    ifb.start = 1'b1;
    n = 0;
    while (!(db_wr == 5 && ifb.s_wren === 1'b1) && n < 2000) begin @(negedge clk); n++; end
    check("b5_reached", 32'(n < 2000), 32'd1);
    rst_b_n = 1'b0;
    ifb.start = 1'b0;
    #1;
    check("b5_rst_s",    32'({ifb.s_addr, ifb.s_data, ifb.s_wren}), 32'd0);
    check("b5_rst_dec",  32'({ifb.enc_addr, ifb.dec_addr, ifb.dec_data, ifb.dec_wren}), 32'd0);
    check("b5_rst_flag", 32'({ifb.done, ifb.msg_valid}), 32'd0);
    @(negedge clk);
    rst_b_n = 1'b1;
    repeat (50) @(negedge clk);
    check("b5_dec_writes", 32'(db_wr), 32'd5);
    check("b5_s_writes", 32'(sb_wr), 32'd10);
    check("b5_idle", 32'({ifb.done, ifb.s_addr}), 32'd0);

    // Random permutations against the software model; some runs carry a bad byte.
    for (int r = 0; r < 20; r++) begin
      rand_perm_b();
      ks_gen(32);
      for (int k = 0; k < 32; k++) begin
        pt = (k % 7 == 3) ? 8'h20 : 8'h61 + 8'($urandom_range(25, 0));
        eb[k] = (r % 4 == 3) ? 8'($urandom) : (ks[k] ^ pt);
      end
      if (r % 4 == 2) eb[(r * 5) % 32] = ks[(r * 5) % 32] ^ 8'h7B;
      mvalid = 1'b1;
      mnwr = 0;
      for (int k = 0; k < 32; k++) md[k] = 8'hEE;
      for (int k = 0; k < 32; k++) begin
        pt = ks[k] ^ eb[k];
        md[k] = pt;
        mnwr++;
        if (!is_text(pt)) begin mvalid = 1'b0; break; end
      end
      ks_gen(mnwr);
      load_b_mem();
      run_b($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_valid", r), 32'(ifb.msg_valid), 32'(mvalid));
      check($sformatf("rnd%0d_nwr", r), 32'(db_wr), 32'(mnwr));
      for (int k = 0; k < 32; k++)
        check($sformatf("rnd%0d_dec%0d", r, k), 32'(db[k]), 32'(md[k]));
      mism = 0;
      for (int x = 0; x < 256; x++) if (sb[x] !== ms[x]) mism++;
      check($sformatf("rnd%0d_s_final", r), 32'(mism), 32'd0);
      end_b($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rc4_prga_decrypt.md
RC4_PRGA_DECRYPT -- requirements
Module: rc4_prga_decrypt

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32; number of ciphertext bytes decrypted per run (1..256).
REQ-002 SHALL have parameter RD_WAIT, default 2; idle cycles between a read-address load state and its data-capture state.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port master_reset_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port start  in  1  level request; run begins on the first clk edge with start=1 in IDLE.
REQ-006 SHALL have port s_addr  out  8  S-array RAM address, registered.
REQ-007 SHALL have port s_data  out  8  S-array RAM write data, registered.
REQ-008 SHALL have port s_wren  out  1  S-array RAM write enable, registered.
REQ-009 SHALL have port s_q  in  8  S-array RAM read data.
REQ-010 SHALL have port enc_addr  out  clog2(MSG_LEN)  ciphertext ROM address, registered.
REQ-011 SHALL have port enc_q  in  8  ciphertext ROM read data.
REQ-012 SHALL have port dec_addr  out  clog2(MSG_LEN)  plaintext RAM address, registered.
REQ-013 SHALL have port dec_data  out  8  plaintext RAM write data, registered.
REQ-014 SHALL have port dec_wren  out  1  plaintext RAM write enable, registered.
REQ-015 SHALL have port done  out  1  run complete, held until start=0.
REQ-016 SHALL have port msg_valid  out  1  qualifies done: 1 = every plaintext byte was 0x61..0x7A or 0x20.

Function
REQ-017 SHALL hold 8-bit i, j, k (byte counter), saved_si, saved_sj; all S-array index arithmetic is modulo 256.
REQ-018 SHALL, on run start, clear i, j, k, done, msg_valid and set an internal valid flag to 1.
REQ-019 SHALL per byte k: i=i+1; read s[i] into saved_si; j=j+saved_si; read s[j] into saved_sj; write saved_sj to s[i]; write saved_si to s[j]; read f=s[saved_si+saved_sj] and enc[k]; write f XOR enc[k] to dec[k].
REQ-020 SHALL use states IDLE, RD_SI, WAIT_A, CAP_SI, RD_SJ, WAIT_B, CAP_SJ, WR_I, WR_J, RD_F, WAIT_C, CAP_F, WR_DEC, NEXT, DONE.
REQ-021 SHALL wait exactly RD_WAIT cycles in each WAIT_x state; s_q and enc_q are sampled only in CAP_x states.
REQ-022 SHALL assert s_wren only during the single cycle following WR_I and WR_J loads; dec_wren only after the WR_DEC load; all three are 0 in every other state.
REQ-023 SHALL present enc_addr=k together with s_addr in RD_F so both reads share one wait window.
REQ-024 SHALL, in WR_DEC, clear the valid flag if the plaintext byte is outside 0x61..0x7A and not 0x20, and still write the byte.
REQ-025 SHALL, in NEXT, go to DONE if k==MSG_LEN-1 or the valid flag is 0, else increment k and go to RD_SI.
REQ-026 SHALL, in DONE, drive done=1 and msg_valid=valid flag; return to IDLE with done=0 when start=0.
REQ-027 SHALL ignore start while not in IDLE or DONE; start held at 1 in DONE does not re-trigger.
REQ-028 SHALL handle i==j correctly: both writes target the same address, the final value being saved_si.
REQ-029 SHALL wrap i, j and the f-address modulo 256 without saturation.

Reset
REQ-030 SHALL, with master_reset_n=0 at any time including mid-run, immediately force state=IDLE, i=j=k=0, all address and data outputs 0, s_wren=dec_wren=0, done=0, msg_valid=0.
REQ-031 SHALL leave RAM contents untouched on reset; a new run requires start after master_reset_n=1.

Verification
REQ-032 SHALL pass: S preloaded identity (s[x]=x), enc[0..2]=0x63,0x67,0x64, MSG_LEN=3 -> dec[0..2]=0x61,0x62,0x63, done=1, msg_valid=1.
REQ-033 SHALL pass: identity S, enc[0]=0x02 (keystream 0x02) -> dec[0]=0x00, early DONE after k=0, msg_valid=0, no dec write at address 1.
REQ-034 SHALL pass: master_reset_n pulsed low during WR_J of byte 5 -> all outputs 0 within the same cycle, state IDLE, no further writes.
REQ-035 SHALL pass: S with s[1]=0xFF, j wraps to 0xFF -> s_addr sequence shows 0x01, 0xFF, 0x01, 0xFF, then read address computed modulo 256.
REQ-036 SHALL pass: start held 1 through DONE -> done stays 1, no second run; start dropped -> done=0 the next cycle.
REQ-037 SHALL pass: scoreboard against a software RC4 PRGA model for 20 random S permutations, MSG_LEN=32 -> bit-exact dec contents and msg_valid.
